// File: rtl/nco_pkg.sv
// Shared types and widths for the voice scheduler and its phase/waveform datapath.
package nco_pkg;
  localparam int PHASE_ACC_W = 16;
  localparam int SAMPLE_W    = 8;
  localparam int NCO_PHASE_W = 7;
  localparam int WFM_W       = 8;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} sched_state_t;

  typedef struct packed {
    logic                   en;
    logic [PHASE_ACC_W-1:0] freq;
    logic [WFM_W-1:0]       wfm_l;
    logic [WFM_W-1:0]       wfm_r;
    logic [WFM_W-1:0]       factor;
  } voice_cfg_t;
endpackage

// File: rtl/voice_regfile.sv
// Per-voice configuration and phase accumulators: one config write port,
// one phase-advance port and a combinational read by voice index.
module voice_regfile
  import nco_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [VW-1:0]          wr_idx_i,
  input  voice_cfg_t             wr_cfg_i,
  input  logic                   phase_rst_i,
  input  logic                   adv_i,
  input  logic [VW-1:0]          adv_idx_i,
  input  logic [VW-1:0]          rd_idx_i,
  output logic                   rd_en_o,
  output logic [NCO_PHASE_W-1:0] rd_phase_o,
  output logic [WFM_W-1:0]       rd_wfm_l_o,
  output logic [WFM_W-1:0]       rd_wfm_r_o,
  output logic [WFM_W-1:0]       rd_factor_o
);
  voice_cfg_t [NUM_VOICES-1:0]                  cfg_q;
  logic       [NUM_VOICES-1:0][PHASE_ACC_W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      acc_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (we_i && wr_idx_i == VW'(i)) cfg_q[i] <= wr_cfg_i;
        // Phase reset beats an advance; the advance uses the pre-write freq.
        if (we_i && phase_rst_i && wr_idx_i == VW'(i))
          acc_q[i] <= '0;
        else if (adv_i && adv_idx_i == VW'(i))
          acc_q[i] <= acc_q[i] + cfg_q[i].freq;
      end
    end
  end

  assign rd_en_o     = cfg_q[rd_idx_i].en;
  assign rd_phase_o  = acc_q[rd_idx_i][PHASE_ACC_W-1 -: NCO_PHASE_W];
  assign rd_wfm_l_o  = cfg_q[rd_idx_i].wfm_l;
  assign rd_wfm_r_o  = cfg_q[rd_idx_i].wfm_r;
  assign rd_factor_o = cfg_q[rd_idx_i].factor;
endmodule

// File: rtl/voice_scheduler.sv
// Walks all voices once per frame tick, issues one datapath lookup per enabled
// voice, advances its phase and accumulates the returned samples into one mix word.
module voice_scheduler
  import nco_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = $clog2(NUM_VOICES),
  localparam int MW         = SAMPLE_W + VW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   cfg_we,
  input  logic [VW-1:0]          cfg_voice,
  input  logic                   cfg_en,
  input  logic [PHASE_ACC_W-1:0] cfg_freq,
  input  logic [WFM_W-1:0]       cfg_wfm_l,
  input  logic [WFM_W-1:0]       cfg_wfm_r,
  input  logic [WFM_W-1:0]       cfg_factor,
  input  logic                   cfg_phase_rst,
  input  logic                   ovr_clr,
  output logic                   nco_phase_dv,
  output logic [NCO_PHASE_W-1:0] nco_phase,
  output logic [WFM_W-1:0]       wfm_num_l,
  output logic [WFM_W-1:0]       wfm_num_r,
  output logic [WFM_W-1:0]       factor,
  input  logic [SAMPLE_W-1:0]    sample_out,
  input  logic                   sample_out_dv,
  output logic [MW-1:0]          mix_out,
  output logic                   mix_dv,
  output logic                   busy,
  output logic                   overrun
);
  sched_state_t           state_q;
  logic [VW-1:0]          v_q;
  logic [MW-1:0]          sum_q, sum_d, mix_out_q;
  logic                   nco_phase_dv_q, mix_dv_q, overrun_q;
  logic [NCO_PHASE_W-1:0] nco_phase_q;
  logic [WFM_W-1:0]       wfm_l_q, wfm_r_q, factor_q;

  voice_cfg_t             wr_cfg;
  logic                   rd_en, adv, last_v;
  logic [NCO_PHASE_W-1:0] rd_phase;
  logic [WFM_W-1:0]       rd_wfm_l, rd_wfm_r, rd_factor;

  assign wr_cfg = '{en: cfg_en, freq: cfg_freq, wfm_l: cfg_wfm_l,
                    wfm_r: cfg_wfm_r, factor: cfg_factor};
  assign adv    = (state_q == S_SCAN) && rd_en;
  assign last_v = (v_q == VW'(NUM_VOICES - 1));
  assign sum_d  = sum_q + MW'(sample_out);

  voice_regfile #(.NUM_VOICES(NUM_VOICES)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (cfg_we),
    .wr_idx_i   (cfg_voice),
    .wr_cfg_i   (wr_cfg),
    .phase_rst_i(cfg_phase_rst),
    .adv_i      (adv),
    .adv_idx_i  (v_q),
    .rd_idx_i   (v_q),
    .rd_en_o    (rd_en),
    .rd_phase_o (rd_phase),
    .rd_wfm_l_o (rd_wfm_l),
    .rd_wfm_r_o (rd_wfm_r),
    .rd_factor_o(rd_factor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      v_q            <= '0;
      sum_q          <= '0;
      mix_out_q      <= '0;
      mix_dv_q       <= 1'b0;
      nco_phase_dv_q <= 1'b0;
      nco_phase_q    <= '0;
      wfm_l_q        <= '0;
      wfm_r_q        <= '0;
      factor_q       <= '0;
      overrun_q      <= 1'b0;
    end else begin
      nco_phase_dv_q <= 1'b0;
      mix_dv_q       <= 1'b0;
      if (frame_tick && state_q != S_IDLE) overrun_q <= 1'b1;
      else if (ovr_clr)                    overrun_q <= 1'b0;

      case (state_q)
        S_IDLE: if (frame_tick) begin
          v_q     <= '0;
          sum_q   <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (rd_en) begin
            nco_phase_dv_q <= 1'b1;
            nco_phase_q    <= rd_phase;
            wfm_l_q        <= rd_wfm_l;
            wfm_r_q        <= rd_wfm_r;
            factor_q       <= rd_factor;
            state_q        <= S_WAIT;
          end else if (last_v) begin
            mix_out_q <= sum_q;
            mix_dv_q  <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            v_q <= v_q + 1'b1;
          end
        end
        S_WAIT: if (sample_out_dv) begin
          if (last_v) begin
            mix_out_q <= sum_d;
            mix_dv_q  <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            sum_q   <= sum_d;
            v_q     <= v_q + 1'b1;
            state_q <= S_SCAN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nco_phase_dv = nco_phase_dv_q;
  assign nco_phase    = nco_phase_q;
  assign wfm_num_l    = wfm_l_q;
  assign wfm_num_r    = wfm_r_q;
  assign factor       = factor_q;
  assign mix_out      = mix_out_q;
  assign mix_dv       = mix_dv_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a fixed 2-cycle stub datapath.
module tb_voice_scheduler;
  localparam int N  = 8;
  localparam int VW = 3;
  localparam int MW = 11;

  logic          clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, cfg_we = 1'b0;
  logic          cfg_en = 1'b0, cfg_phase_rst = 1'b0, ovr_clr = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [15:0]   cfg_freq = '0;
  logic [7:0]    cfg_wfm_l = '0, cfg_wfm_r = '0, cfg_factor = '0;
  logic          nco_phase_dv, sample_out_dv, mix_dv, busy, overrun;
  logic [6:0]    nco_phase;
  logic [7:0]    wfm_num_l, wfm_num_r, factor, sample_out, stub_val = '0;
  logic [MW-1:0] mix_out;
  logic [1:0]    dp_pipe;

  int checks = 0, errors = 0;
  int dv_cyc[16];
  int dv_ph[16];
  int dv_wl[16];
  int dv_wr[16];
  int dv_fac[16];
  int busy1;

  voice_scheduler #(.NUM_VOICES(N)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_en(cfg_en), .cfg_freq(cfg_freq),
    .cfg_wfm_l(cfg_wfm_l), .cfg_wfm_r(cfg_wfm_r), .cfg_factor(cfg_factor),
    .cfg_phase_rst(cfg_phase_rst), .ovr_clr(ovr_clr),
    .nco_phase_dv(nco_phase_dv), .nco_phase(nco_phase), .wfm_num_l(wfm_num_l),
    .wfm_num_r(wfm_num_r), .factor(factor), .sample_out(sample_out),
    .sample_out_dv(sample_out_dv), .mix_out(mix_out), .mix_dv(mix_dv),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Stub datapath: result strobe exactly 2 cycles after the request strobe.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dp_pipe <= '0;
    else        dp_pipe <= {dp_pipe[0], nco_phase_dv};
  assign sample_out_dv = dp_pipe[1];
  assign sample_out    = stub_val;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int v, input logic en, input logic [15:0] f,
                     input logic [7:0] wl, input logic [7:0] wr,
                     input logic [7:0] fac, input logic prst);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = VW'(v); cfg_en = en; cfg_freq = f;
    cfg_wfm_l = wl; cfg_wfm_r = wr; cfg_factor = fac; cfg_phase_rst = prst;
    @(negedge clk);
    cfg_we = 1'b0; cfg_phase_rst = 1'b0;
  endtask

  // kind: 0 none, 1 tick, 2 tick+ovr_clr, 3 phase reset voice 2, 4 async reset,
  // 5 re-tick in the mix_dv cycle (lat2 = second frame latency)
  task automatic run_frame(input int kind, input int inj, output int lat,
                           output int lat2, output int ndv, output int mix);
    int seen = 0;
    int k0 = 0;
    lat = -1; lat2 = -1; ndv = 0; mix = -1; busy1 = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      frame_tick = 1'b0; ovr_clr = 1'b0; cfg_we = 1'b0; cfg_phase_rst = 1'b0;
      if (k == 1) busy1 = int'(busy);
      if (nco_phase_dv) begin
        if (ndv < 16) begin
          dv_cyc[ndv] = k; dv_ph[ndv] = int'(nco_phase);
          dv_wl[ndv] = int'(wfm_num_l); dv_wr[ndv] = int'(wfm_num_r);
          dv_fac[ndv] = int'(factor);
        end
        ndv++;
      end
      if (mix_dv) begin
        if (seen == 0) begin
          lat = k; mix = int'(mix_out);
          if (kind == 5) begin frame_tick = 1'b1; k0 = k; end
        end else begin
          lat2 = k - k0;
        end
        seen++;
      end
      if (k == inj) begin
        case (kind)
          1: frame_tick = 1'b1;
          2: begin frame_tick = 1'b1; ovr_clr = 1'b1; end
          3: begin
            cfg_we = 1'b1; cfg_voice = VW'(2); cfg_en = 1'b1; cfg_freq = 16'h0400;
            cfg_wfm_l = 8'd7; cfg_wfm_r = 8'd9; cfg_factor = 8'h22; cfg_phase_rst = 1'b1;
          end
          4: begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_busy", int'(busy), 0);
            chk("rst_mid_mix_out", int'(mix_out), 0);
            chk("rst_mid_phase", int'(nco_phase), 0);
            chk("rst_mid_wfm_l", int'(wfm_num_l), 0);
            chk("rst_mid_factor", int'(factor), 0);
          end
          default: ;
        endcase
      end
      if (kind == 4 && k == inj + 2) rst_n = 1'b1;
      if (seen > 0 && (kind != 5 || seen > 1)) break;
    end
  endtask

  initial begin
    int lat, lat2, ndv, mix;
    repeat (3) @(negedge clk);
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_dv", int'(mix_dv), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_dv", int'(nco_phase_dv), 0);
    chk("rst_wfm_l", int'(wfm_num_l), 0);
    rst_n = 1'b1;

    // Voice 0 only
    stub_val = 8'h11;
    cfg(0, 1'b1, 16'h0200, 8'd3, 8'd5, 8'h40, 1'b0);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("v0_lat1", lat, 12);
    chk("v0_busy", busy1, 1);
    chk("v0_mix1", mix, 'h11);
    chk("v0_ndv", ndv, 1);
    chk("v0_dvcyc", dv_cyc[0], 2);
    chk("v0_ph1", dv_ph[0], 0);
    chk("v0_wl", dv_wl[0], 3);
    chk("v0_wr", dv_wr[0], 5);
    chk("v0_fac", dv_fac[0], 'h40);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("v0_lat2", lat, 12);
    chk("v0_ph2", dv_ph[0], 1);

    // Wrap: acc 0 -> 1, then freq 0xFFFF: issue 0 (acc->0), 0 (acc->FFFF), 0x7F
    cfg(0, 1'b1, 16'h0001, 8'd3, 8'd5, 8'h40, 1'b1);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("wrap_ph0", dv_ph[0], 0);
    cfg(0, 1'b1, 16'hFFFF, 8'd3, 8'd5, 8'h40, 1'b0);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("wrap_ph1", dv_ph[0], 0);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("wrap_ph2", dv_ph[0], 0);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("wrap_ph3", dv_ph[0], 'h7F);

    // All eight voices, stub returns 0xFF
    stub_val = 8'hFF;
    for (int v = 0; v < N; v++) cfg(v, 1'b1, 16'h0800, 8'(v), 8'(v + 8), 8'(v), 1'b1);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("all_lat", lat, 33);
    chk("all_mix", mix, 'h7F8);
    chk("all_ndv", ndv, 8);
    chk("all_space", dv_cyc[1] - dv_cyc[0], 4);
    chk("all_span", dv_cyc[7] - dv_cyc[0], 28);
    chk("all_wl5", dv_wl[5], 5);
    chk("all_wr7", dv_wr[7], 15);

    // Overrun
    run_frame(1, 5, lat, lat2, ndv, mix);
    chk("ovr_lat", lat, 33);
    chk("ovr_mix", mix, 'h7F8);
    chk("ovr_set", int'(overrun), 1);
    repeat (4) @(negedge clk);
    chk("ovr_sticky", int'(overrun), 1);
    run_frame(2, 5, lat, lat2, ndv, mix);
    chk("ovr_set_wins", int'(overrun), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // Phase reset on voice 2 in the cycle it scans
    stub_val = 8'h33;
    for (int v = 0; v < N; v++) cfg(v, 1'b0, 16'h0000, 8'd0, 8'd0, 8'd0, 1'b1);
    cfg(2, 1'b1, 16'h0400, 8'd7, 8'd9, 8'h22, 1'b0);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("prst_ph0", dv_ph[0], 0);
    chk("prst_lat", lat, 12);
    run_frame(3, 3, lat, lat2, ndv, mix);
    chk("prst_ph_old", dv_ph[0], 2);
    chk("prst_mix", mix, 'h33);
    run_frame(0, 0, lat, lat2, ndv, mix);
    chk("prst_ph_zero", dv_ph[0], 0);

    // Reset during WAIT of voice 2 (issue in cycle 4)
    run_frame(4, 5, lat, lat2, ndv, mix);
    chk("rst_no_mix", lat, -1);
    run_frame(5, 0, lat, lat2, ndv, mix);
    chk("empty_lat", lat, 9);
    chk("empty_mix", mix, 0);
    chk("empty_ndv", ndv, 0);
    chk("retick_lat", lat2, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
